// File: rtl/dmem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_io_responder_pkg
//  Purpose  : Shared definitions for the PMIPS data-port responder.
//             Holds the IO word offsets (DISP/SW/TMR) within the 16-byte IO
//             window and the hex-to-7-segment glyph function.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_io_responder_pkg;

    // Word offsets inside the IO window (byte offset / 2, i.e. addr[3:1]).
    localparam logic [2:0] c_io_disp = 3'd0;
    localparam logic [2:0] c_io_sw   = 3'd1;
    localparam logic [2:0] c_io_tmr  = 3'd2;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_io_responder_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debounce
//  Purpose  : Two-flop synchronizer followed by a stability counter for one
//             raw slide switch. A change is accepted only after the
//             synchronized level has differed from the accepted level for
//             DEBOUNCE_CYCLES consecutive clock edges.
//  Ports    : clock  - system clock
//             reset  - asynchronous active-high reset
//             pin    - raw asynchronous switch input
//             db     - debounced switch level
//  Revision : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic db
);

    // Counter only has to hold 0 .. DEBOUNCE_CYCLES-1: the edge on which it
    // would reach DEBOUNCE_CYCLES is the edge that accepts the new level.
    localparam int c_CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_last = c_CW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [c_CW-1:0] r_cnt;
    logic            r_db;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_db    <= 1'b0;
        end else begin
            r_sync1 <= pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db = r_db;

endmodule
`default_nettype wire

// File: rtl/dmem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_io_responder
//  Purpose  : Single-cycle data-memory responder for the PMIPS 16-bit core.
//             Serves a word RAM at the bottom of the address space and a
//             16-byte IO window at IO_BASE holding the 7-segment display
//             register (DISP), the debounced switches (SW) and, when the
//             DMEM_TIMER_EN macro is defined, a free-running timer (TMR).
//  Ports    : clock, reset       - clock and async active-high reset
//             addr, wdata        - byte address (bit 0 ignored), write data
//             write, read        - write / read enables
//             rdata              - combinational read data (0 when read=0)
//             io_sw0, io_sw1     - raw slide switches
//             io_display         - active-low 7-seg segments {g,f,e,d,c,b,a}
//  Config   : `define DMEM_TIMER_EN to build the TMR counter.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_io_responder
    import dmem_io_responder_pkg::*;
#(
    parameter int          RAM_WORDS       = 128,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [15:0] IO_BASE         = 16'hFFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        write,
    input  logic        read,
    output logic [15:0] rdata,
    input  logic        io_sw0,
    input  logic        io_sw1,
    output logic [6:0]  io_display
);

    localparam int          c_AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [16:0] c_ram_bytes = 17'(2 * RAM_WORDS);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic            w_ram_sel;
    logic            w_io_sel;
    logic [2:0]      w_io_off;
    logic [c_AW-1:0] w_ram_idx;
    logic            w_unused_addr0;

    assign w_ram_sel      = ({1'b0, addr} < c_ram_bytes);
    assign w_io_sel       = (addr[15:4] == IO_BASE[15:4]);
    assign w_io_off       = addr[3:1];
    assign w_ram_idx      = addr[c_AW:1];
    // Byte lane select does not exist on this word-only port.
    assign w_unused_addr0 = addr[0];

    // ------------------------------------------------------------------
    // Word RAM: asynchronous read, synchronous write, not reset
    // ------------------------------------------------------------------
    logic [15:0] r_mem [RAM_WORDS];

    always_ff @(posedge clock) begin
        if (write && w_ram_sel) begin
            r_mem[w_ram_idx] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // DISP register: only the nibble is stored, upper bits read as 0
    // ------------------------------------------------------------------
    logic [3:0] r_disp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp <= 4'h0;
        end else if (write && w_io_sel && (w_io_off == c_io_disp)) begin
            r_disp <= wdata[3:0];
        end
    end

    assign io_display = hex_to_seg7(r_disp);

    // ------------------------------------------------------------------
    // Switch debouncers
    // ------------------------------------------------------------------
    logic w_sw0_db;
    logic w_sw1_db;

    switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_sw0 (
        .clock (clock),
        .reset (reset),
        .pin   (io_sw0),
        .db    (w_sw0_db)
    );

    switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_sw1 (
        .clock (clock),
        .reset (reset),
        .pin   (io_sw1),
        .db    (w_sw1_db)
    );

    // ------------------------------------------------------------------
    // Optional timer
    // ------------------------------------------------------------------
    logic [15:0] w_tmr_rd;

`ifdef DMEM_TIMER_EN
    logic [15:0] r_tmr;
    logic        w_tmr_we;

    assign w_tmr_we = write && w_io_sel && (w_io_off == c_io_tmr);

    // A load takes priority over the increment so software reads back
    // exactly what it wrote on the following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmr <= 16'h0000;
        end else if (w_tmr_we) begin
            r_tmr <= wdata;
        end else begin
            r_tmr <= r_tmr + 16'h0001;
        end
    end

    assign w_tmr_rd = r_tmr;
`else
    assign w_tmr_rd = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Read mux: reads see state before any same-cycle write commits
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 16'h0000;
        if (read) begin
            if (w_ram_sel) begin
                rdata = r_mem[w_ram_idx];
            end else if (w_io_sel) begin
                case (w_io_off)
                    c_io_disp: rdata = {12'h000, r_disp};
                    c_io_sw:   rdata = {14'h0000, w_sw1_db, w_sw0_db};
                    c_io_tmr:  rdata = w_tmr_rd;
                    default:   rdata = 16'h0000;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_io_responder
//  Purpose  : Self-checking bench for dmem_io_responder (table-driven vectors
//             plus hand-written multi-cycle sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_io_responder;

    logic        clock;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        write;
    logic        read;
    logic [15:0] rdata;
    logic        io_sw0;
    logic        io_sw1;
    logic [6:0]  io_display;

    int n_checks;
    int n_fail;

    dmem_io_responder #(
        .RAM_WORDS       (128),
        .DEBOUNCE_CYCLES (4),
        .IO_BASE         (16'hFFF0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .write      (write),
        .read       (read),
        .rdata      (rdata),
        .io_sw0     (io_sw0),
        .io_sw1     (io_sw1),
        .io_display (io_display)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
        logic        rd;
        logic [15:0] exp_rdata;  // sampled before the edge
        logic [6:0]  exp_disp;   // sampled after the edge
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdata = d; write = 1'b1; read = 1'b0;
        cyc();
        write = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        addr = a; read = 1'b1; write = 1'b0;
        #1;
        check(name, rdata, exp);
        read = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0; addr = '0; wdata = '0; write = 1'b0; read = 1'b0;
        io_sw0 = 1'b0; io_sw1 = 1'b0;

        // ---------------- reset asserted mid-cycle ----------------
        @(posedge clock);
        #3 reset = 1'b1;
        #1 check("reset_display", {9'h0, io_display}, {9'h0, 7'b1000000});
        check("reset_rdata_idle", rdata, 16'h0000);
        rd_check("reset_sw", 16'hFFF2, 16'h0000);
        cyc(); cyc();
        #2 reset = 1'b0;
        cyc(); cyc();
        rd_check("post_reset_disp_reg", 16'hFFF0, 16'h0000);

        // ---------------- table-driven vectors ----------------
        vecs[0]  = '{"ram_write_init", 16'h0010, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 7'b1000000};
        vecs[1]  = '{"ram_rw_old",     16'h0010, 16'h1234, 1'b1, 1'b1, 16'hAAAA, 7'b1000000};
        vecs[2]  = '{"ram_read_even",  16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 7'b1000000};
        vecs[3]  = '{"ram_read_odd",   16'h0011, 16'h0000, 1'b0, 1'b1, 16'h1234, 7'b1000000};
        vecs[4]  = '{"disp_write_8",   16'hFFF0, 16'hABC8, 1'b1, 1'b1, 16'h0000, 7'b0000000};
        vecs[5]  = '{"disp_read_8",    16'hFFF0, 16'h0000, 1'b0, 1'b1, 16'h0008, 7'b0000000};
        vecs[6]  = '{"sw_write_ign",   16'hFFF2, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 7'b0000000};
        vecs[7]  = '{"sw_read_after",  16'hFFF2, 16'h0000, 1'b0, 1'b1, 16'h0000, 7'b0000000};
        vecs[8]  = '{"gap_read",       16'h0100, 16'h0000, 1'b0, 1'b1, 16'h0000, 7'b0000000};
        vecs[9]  = '{"io_fff6_read",   16'hFFF6, 16'h0000, 1'b0, 1'b1, 16'h0000, 7'b0000000};
        vecs[10] = '{"read_disabled",  16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 7'b0000000};
        vecs[11] = '{"disp_write_F",   16'hFFF0, 16'h123F, 1'b1, 1'b0, 16'h0000, 7'b0001110};
        vecs[12] = '{"disp_read_F",    16'hFFF0, 16'h0000, 1'b0, 1'b1, 16'h000F, 7'b0001110};
        vecs[13] = '{"disp_write_5",   16'hFFF1, 16'h0005, 1'b1, 1'b0, 16'h0000, 7'b0010010};

        for (int i = 0; i < 14; i++) begin
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            write = vecs[i].wr;
            read  = vecs[i].rd;
            #1;
            check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            cyc();
            check({vecs[i].name, "_disp"}, {9'h0, io_display}, {9'h0, vecs[i].exp_disp});
        end
        write = 1'b0; read = 1'b0;

        // ---------------- debounce: clean edge on sw1 ----------------
        io_sw1 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            cyc();
            rd_check($sformatf("sw1_edge_n%0d", n), 16'hFFF2, (n >= 6) ? 16'h0002 : 16'h0000);
        end

        // ---------------- debounce: 3-cycle glitch on sw0 ----------------
        io_sw0 = 1'b1;
        cyc(); cyc(); cyc();
        io_sw0 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            cyc();
            rd_check($sformatf("sw0_glitch_n%0d", n), 16'hFFF2, 16'h0002);
        end

        // ---------------- RAM scan around gap / IO writes ----------------
        for (int i = 0; i < 128; i++) wr_word(16'(2 * i), 16'h5A00 ^ 16'(i));
        wr_word(16'h0100, 16'hFFFF);
        wr_word(16'h01FE, 16'hFFFF);
        wr_word(16'hFFF6, 16'hFFFF);
        wr_word(16'hFFFE, 16'hFFFF);
        rd_check("gap_read_after_wr", 16'h0100, 16'h0000);
        rd_check("fff6_read_after_wr", 16'hFFF6, 16'h0000);
        for (int i = 0; i < 128; i++)
            rd_check($sformatf("ram_scan_%0d", i), 16'(2 * i), 16'h5A00 ^ 16'(i));

        // ---------------- timer ----------------
        wr_word(16'hFFF4, 16'hFFFE);
`ifdef DMEM_TIMER_EN
        rd_check("tmr_load", 16'hFFF4, 16'hFFFE);
        cyc();
        rd_check("tmr_inc", 16'hFFF4, 16'hFFFF);
        cyc();
        rd_check("tmr_wrap", 16'hFFF4, 16'h0000);
`else
        rd_check("tmr_absent_0", 16'hFFF4, 16'h0000);
        cyc();
        rd_check("tmr_absent_1", 16'hFFF4, 16'h0000);
        cyc();
        rd_check("tmr_absent_2", 16'hFFF4, 16'h0000);
`endif

        // ---------------- reset mid-count discards pending change ----------------
        io_sw0 = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        #1 reset = 1'b1;
        #1 check("reset2_display", {9'h0, io_display}, {9'h0, 7'b1000000});
        rd_check("reset2_sw", 16'hFFF2, 16'h0000);
        #1 reset = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            cyc();
            if (n >= 5)
                rd_check($sformatf("sw_after_reset_n%0d", n), 16'hFFF2,
                         (n >= 6) ? 16'h0003 : 16'h0000);
        end
        rd_check("ram_kept_over_reset", 16'h0010, 16'h5A08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
